// File: rtl/pito_pkg.sv
// Shared barrel-core constants: hart count, hart index width, timer compare reset value.
package pito_pkg;

   localparam int unsigned NUM_HARTS      = 8;
   localparam int unsigned HART_CNT_WIDTH = 3;
   localparam int unsigned MTIME_WIDTH    = 64;

   localparam logic [MTIME_WIDTH-1:0] IRQ_TCMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

endpackage : pito_pkg

// File: rtl/rv32_hart_irq_slot.sv
// Per-hart interrupt state: mtimecmp, registered timer compare, MVU pending latch and overrun flag.
module rv32_hart_irq_slot
   import pito_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [MTIME_WIDTH-1:0] mtime,
   input  logic                   tcmp_we,
   input  logic                   tcmp_hi,
   input  logic [31:0]            tcmp_wdata,
   input  logic                   done,
   input  logic                   ack,
   output logic                   time_irq,
   output logic                   mvu_irq,
   output logic                   mvu_overrun
);

   logic [MTIME_WIDTH-1:0] mtimecmp;

   // Half-word compare writes; the untouched half keeps its value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mtimecmp <= IRQ_TCMP_RESET;
      end else if (tcmp_we) begin
         if (tcmp_hi) mtimecmp[63:32] <= tcmp_wdata;
         else         mtimecmp[31:0]  <= tcmp_wdata;
      end
   end

   // Timer level is the compare of pre-edge values, one register stage late.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) time_irq <= 1'b0;
      else        time_irq <= (mtime >= mtimecmp);
   end

   // A new completion beats a same-cycle ack; ack always clears overrun.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mvu_irq     <= 1'b0;
         mvu_overrun <= 1'b0;
      end else begin
         if (done)     mvu_irq <= 1'b1;
         else if (ack) mvu_irq <= 1'b0;

         if (ack)                  mvu_overrun <= 1'b0;
         else if (done && mvu_irq) mvu_overrun <= 1'b1;
      end
   end

endmodule : rv32_hart_irq_slot

// File: rtl/rv32_barrel_irq_src.sv
// Interrupt source for the barrel core: shared mtime with prescaler, per-hart timer and
// MVU-completion interrupt slots, and hart-selected views for the CSR stage.
module rv32_barrel_irq_src #(
   parameter int unsigned NUM_HARTS      = pito_pkg::NUM_HARTS,
   parameter int unsigned HART_CNT_WIDTH = pito_pkg::HART_CNT_WIDTH,
   parameter int unsigned TICK_DIV       = 1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_HARTS-1:0]      mvu_done,
   input  logic                      irq_ack_valid,
   input  logic [HART_CNT_WIDTH-1:0] irq_ack_hart,
   input  logic                      tcmp_we,
   input  logic [HART_CNT_WIDTH-1:0] tcmp_hart,
   input  logic                      tcmp_hi,
   input  logic [31:0]               tcmp_wdata,
   input  logic [HART_CNT_WIDTH-1:0] hart_id_i,
   output logic [NUM_HARTS-1:0]      mvu_irq,
   output logic [NUM_HARTS-1:0]      time_irq,
   output logic [NUM_HARTS-1:0]      mvu_overrun,
   output logic                      time_irq_sel,
   output logic                      mvu_irq_sel,
   output logic [63:0]               mtime
);

   localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [PRE_W-1:0]     pre;
   logic                 tick;
   logic [NUM_HARTS-1:0] slot_we;
   logic [NUM_HARTS-1:0] slot_ack;

   assign tick = (pre == PRE_W'(TICK_DIV - 1));

   // Prescaler and free-running time base; mtime wraps silently.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre   <= '0;
         mtime <= '0;
      end else if (tick) begin
         pre   <= '0;
         mtime <= mtime + 64'd1;
      end else begin
         pre   <= pre + PRE_W'(1);
      end
   end

   // Out-of-range hart indices match no slot, so such writes and acks fall away.
   always_comb begin
      slot_we  = '0;
      slot_ack = '0;
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
         slot_we[h]  = tcmp_we && (tcmp_hart == HART_CNT_WIDTH'(h));
         slot_ack[h] = irq_ack_valid && (irq_ack_hart == HART_CNT_WIDTH'(h));
      end
   end

   for (genvar h = 0; h < NUM_HARTS; h++) begin : g_slot
      rv32_hart_irq_slot u_slot (
         .clk         (clk),
         .rst_n       (rst_n),
         .mtime       (mtime),
         .tcmp_we     (slot_we[h]),
         .tcmp_hi     (tcmp_hi),
         .tcmp_wdata  (tcmp_wdata),
         .done        (mvu_done[h]),
         .ack         (slot_ack[h]),
         .time_irq    (time_irq[h]),
         .mvu_irq     (mvu_irq[h]),
         .mvu_overrun (mvu_overrun[h])
      );
   end

   // CSR-stage views; an out-of-range hart reads as no interrupt.
   always_comb begin
      time_irq_sel = 1'b0;
      mvu_irq_sel  = 1'b0;
      for (int unsigned h = 0; h < NUM_HARTS; h++) begin
         if (hart_id_i == HART_CNT_WIDTH'(h)) begin
            time_irq_sel = time_irq[h];
            mvu_irq_sel  = mvu_irq[h];
         end
      end
   end

endmodule : rv32_barrel_irq_src

// File: tb/tb_rv32_barrel_irq_src.sv
// Randomised and directed bench for rv32_barrel_irq_src against an arithmetic reference model.
module tb_rv32_barrel_irq_src;

   localparam int NH = 8;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  mvu_done;
   logic        irq_ack_valid;
   logic [2:0]  irq_ack_hart;
   logic        tcmp_we;
   logic [2:0]  tcmp_hart;
   logic        tcmp_hi;
   logic [31:0] tcmp_wdata;
   logic [2:0]  hart_id;

   logic [7:0]  mvu_irq, time_irq, mvu_overrun;
   logic        time_irq_sel, mvu_irq_sel;
   logic [63:0] mtime;
   logic [7:0]  mvu_irq4, time_irq4, mvu_overrun4;
   logic        time_irq_sel4, mvu_irq_sel4;
   logic [63:0] mtime4;

   always #5 clk = ~clk;

   rv32_barrel_irq_src #(.NUM_HARTS(8), .HART_CNT_WIDTH(3), .TICK_DIV(1)) dut (
      .clk(clk), .rst_n(rst_n), .mvu_done(mvu_done), .irq_ack_valid(irq_ack_valid),
      .irq_ack_hart(irq_ack_hart), .tcmp_we(tcmp_we), .tcmp_hart(tcmp_hart),
      .tcmp_hi(tcmp_hi), .tcmp_wdata(tcmp_wdata), .hart_id_i(hart_id),
      .mvu_irq(mvu_irq), .time_irq(time_irq), .mvu_overrun(mvu_overrun),
      .time_irq_sel(time_irq_sel), .mvu_irq_sel(mvu_irq_sel), .mtime(mtime));

   rv32_barrel_irq_src #(.NUM_HARTS(8), .HART_CNT_WIDTH(3), .TICK_DIV(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .mvu_done(mvu_done), .irq_ack_valid(irq_ack_valid),
      .irq_ack_hart(irq_ack_hart), .tcmp_we(tcmp_we), .tcmp_hart(tcmp_hart),
      .tcmp_hi(tcmp_hi), .tcmp_wdata(tcmp_wdata), .hart_id_i(hart_id),
      .mvu_irq(mvu_irq4), .time_irq(time_irq4), .mvu_overrun(mvu_overrun4),
      .time_irq_sel(time_irq_sel4), .mvu_irq_sel(mvu_irq_sel4), .mtime(mtime4));

   int n_checks = 0;
   int n_fail   = 0;

   // Reference state: plain integers and per-hart arrays.
   logic [63:0] m_mtime, m4_mtime;
   int          m4_pre;
   logic [63:0] m_cmp [NH];
   bit          m_pend [NH];
   bit          m_ovr  [NH];
   bit          m_tirq [NH];
   bit          m4_tirq[NH];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic idle();
      mvu_done      = '0;
      irq_ack_valid = 1'b0;
      irq_ack_hart  = '0;
      tcmp_we       = 1'b0;
      tcmp_hart     = '0;
      tcmp_hi       = 1'b0;
      tcmp_wdata    = '0;
   endtask

   task automatic model_reset();
      m_mtime  = '0;
      m4_mtime = '0;
      m4_pre   = 0;
      for (int h = 0; h < NH; h++) begin
         m_cmp[h]   = 64'hFFFF_FFFF_FFFF_FFFF;
         m_pend[h]  = 1'b0;
         m_ovr[h]   = 1'b0;
         m_tirq[h]  = 1'b0;
         m4_tirq[h] = 1'b0;
      end
   endtask

   task automatic check_all();
      logic [7:0] ev_m, ev_t, ev_o, ev_t4;
      for (int h = 0; h < NH; h++) begin
         ev_m[h]  = m_pend[h];
         ev_t[h]  = m_tirq[h];
         ev_o[h]  = m_ovr[h];
         ev_t4[h] = m4_tirq[h];
      end
      chk("mvu_irq",      64'(mvu_irq),      64'(ev_m));
      chk("time_irq",     64'(time_irq),     64'(ev_t));
      chk("mvu_overrun",  64'(mvu_overrun),  64'(ev_o));
      chk("mvu_irq_sel",  64'(mvu_irq_sel),  64'(ev_m[hart_id]));
      chk("time_irq_sel", 64'(time_irq_sel), 64'(ev_t[hart_id]));
      chk("mtime",        mtime,             m_mtime);
      chk("mtime_div4",   mtime4,            m4_mtime);
      chk("time_irq_div4", 64'(time_irq4),   64'(ev_t4));
      chk("mvu_irq_div4", 64'(mvu_irq4),     64'(ev_m));
   endtask

   // Apply the rules to the current inputs, advance one clock, then compare.
   task automatic step();
      bit ackh;
      for (int h = 0; h < NH; h++) begin
         m_tirq[h]  = (m_mtime  >= m_cmp[h]);
         m4_tirq[h] = (m4_mtime >= m_cmp[h]);
      end
      if (tcmp_we) begin
         if (tcmp_hi) m_cmp[tcmp_hart][63:32] = tcmp_wdata;
         else         m_cmp[tcmp_hart][31:0]  = tcmp_wdata;
      end
      for (int h = 0; h < NH; h++) begin
         ackh = irq_ack_valid && (int'(irq_ack_hart) == h);
         if (ackh)                         m_ovr[h] = 1'b0;
         else if (mvu_done[h] && m_pend[h]) m_ovr[h] = 1'b1;
         if (mvu_done[h]) m_pend[h] = 1'b1;
         else if (ackh)   m_pend[h] = 1'b0;
      end
      m_mtime = m_mtime + 64'd1;
      if (m4_pre == 3) begin
         m4_pre   = 0;
         m4_mtime = m4_mtime + 64'd1;
      end else begin
         m4_pre++;
      end
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic tcmp_write(input int hart, input bit hi, input logic [31:0] data);
      idle();
      tcmp_we    = 1'b1;
      tcmp_hart  = 3'(hart);
      tcmp_hi    = hi;
      tcmp_wdata = data;
      step();
      idle();
   endtask

   initial begin
      int guard;
      idle();
      hart_id = '0;
      model_reset();

      // Reset state, then mtime counting 1, 2, 3.
      @(negedge clk);
      check_all();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step();

      // Timer compare on hart 2 rises at 20, falls after raising compare to 1000.
      hart_id = 3'd2;
      tcmp_write(2, 1'b0, 32'd20);
      tcmp_write(2, 1'b1, 32'd0);
      guard = 0;
      while (m_mtime < 64'd25 && guard < 100) begin
         step();
         guard++;
      end
      chk("tirq2_rise", 64'(time_irq[2]), 64'd1);
      chk("tirq_others", 64'(time_irq & 8'hFB), 64'd0);
      tcmp_write(2, 1'b0, 32'd1000);
      step();
      chk("tirq2_fall", 64'(time_irq[2]), 64'd0);

      // MVU completion on hart 5, then ack.
      hart_id = 3'd5;
      mvu_done = 8'h20;
      step();
      idle();
      chk("mvu5_sel", 64'(mvu_irq_sel), 64'd1);
      irq_ack_valid = 1'b1;
      irq_ack_hart  = 3'd5;
      step();
      idle();
      chk("mvu5_ack", 64'(mvu_irq[5]), 64'd0);

      // Overrun on hart 3, cleared by ack.
      mvu_done = 8'h08; step();
      mvu_done = 8'h08; step();
      idle();
      chk("ovr3_set", 64'(mvu_overrun[3]), 64'd1);
      irq_ack_valid = 1'b1; irq_ack_hart = 3'd3; step(); idle();
      chk("ovr3_clr", 64'({mvu_irq[3], mvu_overrun[3]}), 64'd0);

      // Same-cycle completion and ack on hart 1 while pending: set wins, no overrun.
      mvu_done = 8'h02; step();
      mvu_done = 8'h02; irq_ack_valid = 1'b1; irq_ack_hart = 3'd1; step(); idle();
      chk("race1_irq", 64'(mvu_irq[1]), 64'd1);
      chk("race1_ovr", 64'(mvu_overrun[1]), 64'd0);

      // Ack of an idle hart does nothing.
      irq_ack_valid = 1'b1; irq_ack_hart = 3'd6; step(); idle();

      // Wrap of the divided time base with mtimecmp[0] = 0.
      tcmp_write(0, 1'b0, 32'd0);
      tcmp_write(0, 1'b1, 32'd0);
      step();
      force dut4.mtime = 64'hFFFF_FFFF_FFFF_FFFD;
      #1;
      release dut4.mtime;
      m4_mtime = 64'hFFFF_FFFF_FFFF_FFFD;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("wrap_tirq0", 64'(time_irq4[0]), 64'd1);
      end
      chk("wrap_mtime_small", 64'(mtime4 < 64'd8), 64'd1);

      // Randomised traffic.
      for (int i = 0; i < 400; i++) begin
         for (int h = 0; h < NH; h++) mvu_done[h] = ($urandom_range(0, 5) == 0);
         irq_ack_valid = ($urandom_range(0, 2) == 0);
         irq_ack_hart  = 3'($urandom_range(0, 7));
         tcmp_we       = ($urandom_range(0, 3) == 0);
         tcmp_hart     = 3'($urandom_range(0, 7));
         tcmp_hi       = ($urandom_range(0, 3) == 0);
         if (tcmp_hi) tcmp_wdata = ($urandom_range(0, 3) == 0) ? 32'd1 : 32'd0;
         else         tcmp_wdata = m_mtime[31:0] + 32'($urandom_range(0, 40)) - 32'd20;
         hart_id = 3'($urandom_range(0, 7));
         step();
      end
      idle();

      // Mid-operation asynchronous reset drops pending state immediately.
      mvu_done = 8'hFF; step(); idle();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule : tb_rv32_barrel_irq_src
